spi_child_rx: RTL and testbench

SPI child-side receiver for the FPGA SPI link. Consumes SCL/SS/MOSI from the SPI parent transmitter: CPOL 0, CPHA 1, 250 kHz SCL, MSB first. Each transfer is a 12-bit word sent as two 8-bit bytes, each framed by its own SS-low window. The block oversamples the three lines on the local 50 MHz clock, reassembles the word and presents it with a one-cycle valid strobe to downstream logic.

---
 rtl/spi_child_rx_if.sv | 21 ++
 rtl/spi_child_rx.sv | 170 +++++++++++++++++
 tb/tb_spi_child_rx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_child_rx_if.sv
// SPI child receiver bus: parent-driven serial lines plus the received-word outputs.
interface spi_child_rx_if;
    logic        SCL;
    logic        SS;
    logic        MOSI;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic        pad_err;
    logic        frame_err;
    logic        busy;

    modport master (
        output SCL, SS, MOSI,
        input  rx_data, rx_valid, pad_err, frame_err, busy
    );

    modport slave (
        input  SCL, SS, MOSI,
        output rx_data, rx_valid, pad_err, frame_err, busy
    );
endinterface

// File: rtl/spi_child_rx.sv
// SPI child receiver (CPOL 0, CPHA 1, MSB first): oversamples SCL/SS/MOSI on clk and
// reassembles a 12-bit word from two SS-framed bytes, with a one-cycle valid strobe.
module spi_child_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_TIMEOUT = 1000
) (
    input  logic           clk,
    input  logic           rst,
    spi_child_rx_if.slave  bus
);
    localparam int TW = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BYTE0, GAP, BYTE1} state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_ss_sync, r_mosi_sync;
    logic                   r_scl_prev, r_ss_prev, r_mosi_prev;
    logic                   r_ev_ss_fall, r_ev_ss_rise, r_ev_scl_fall;
    logic                   w_scl, w_ss, w_mosi;
    logic                   w_ss_fall, w_ss_rise, w_scl_fall;

    state_t        r_state, w_state;
    logic [7:0]    r_shift, w_shift;
    logic [3:0]    r_cnt, w_cnt;
    logic [TW-1:0] r_timer, w_timer;
    logic [7:0]    r_hi, w_hi;
    logic [11:0]   r_rx_data, w_rx_data;
    logic          r_pad, w_pad;
    logic          r_valid, w_valid;
    logic          r_ferr, w_ferr;
    logic [7:0]    w_shift_in;
    logic [3:0]    w_cnt_inc;

    // SS resets high so a select already low at reset release shows up as a fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_scl_prev  <= 1'b0;
            r_ss_prev   <= 1'b1;
            r_mosi_prev <= 1'b0;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], bus.SCL};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            r_scl_prev  <= w_scl;
            r_ss_prev   <= w_ss;
            r_mosi_prev <= w_mosi;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall  = r_ss_prev & ~w_ss;
    assign w_ss_rise  = ~r_ss_prev & w_ss;
    assign w_scl_fall = r_scl_prev & ~w_scl & ~w_ss;

    // Events are registered; r_mosi_prev is the MOSI value aligned with r_ev_scl_fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ev_ss_fall  <= 1'b0;
            r_ev_ss_rise  <= 1'b0;
            r_ev_scl_fall <= 1'b0;
        end else begin
            r_ev_ss_fall  <= w_ss_fall;
            r_ev_ss_rise  <= w_ss_rise;
            r_ev_scl_fall <= w_scl_fall;
        end
    end

    assign w_shift_in = {r_shift[6:0], r_mosi_prev};
    assign w_cnt_inc  = (r_cnt == 4'd9) ? 4'd9 : r_cnt + 4'd1;

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_cnt     = r_cnt;
        w_timer   = r_timer;
        w_hi      = r_hi;
        w_rx_data = r_rx_data;
        w_pad     = r_pad;
        w_valid   = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ev_ss_fall) begin
                    w_shift = '0;
                    w_cnt   = '0;
                    w_state = BYTE0;
                end
            end
            BYTE0: begin
                if (r_ev_ss_rise) begin
                    if (r_cnt == 4'd8) begin
                        w_hi    = r_shift;
                        w_cnt   = '0;
                        w_timer = '0;
                        w_state = GAP;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = IDLE;
                    end
                end else if (r_ev_scl_fall) begin
                    w_shift = w_shift_in;
                    w_cnt   = w_cnt_inc;
                end
            end
            GAP: begin
                w_timer = r_timer + TW'(1);
                // Timeout wins over an ss_fall arriving in the same cycle.
                if (r_timer == TW'(GAP_TIMEOUT - 1)) begin
                    w_ferr  = 1'b1;
                    w_hi    = '0;
                    w_state = IDLE;
                end else if (r_ev_ss_fall) begin
                    w_shift = '0;
                    w_cnt   = '0;
                    w_state = BYTE1;
                end
            end
            BYTE1: begin
                if (r_ev_ss_rise) begin
                    if (r_cnt == 4'd8) begin
                        w_rx_data = {r_hi[3:0], r_shift};
                        w_pad     = |r_hi[7:4];
                        w_valid   = 1'b1;
                    end else begin
                        w_ferr    = 1'b1;
                    end
                    w_state = IDLE;
                end else if (r_ev_scl_fall) begin
                    w_shift = w_shift_in;
                    w_cnt   = w_cnt_inc;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_hi      <= '0;
            r_rx_data <= '0;
            r_pad     <= 1'b0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_cnt     <= w_cnt;
            r_timer   <= w_timer;
            r_hi      <= w_hi;
            r_rx_data <= w_rx_data;
            r_pad     <= w_pad;
            r_valid   <= w_valid;
            r_ferr    <= w_ferr;
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.pad_err   = r_pad;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_spi_child_rx.sv
// Bench for spi_child_rx: directed vector table, latency/reset sequences and random
// two-byte transfers checked against a transfer-level model of the receiver.
module tb_spi_child_rx;
    localparam int S  = 2;
    localparam int GT = 1000;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    spi_child_rx_if bus();
    spi_child_rx #(.SYNC_STAGES(S), .GAP_TIMEOUT(GT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          is_v;
        logic [11:0] d;
        logic        p;
    } ev_t;

    typedef struct {
        logic [7:0]  b0;
        int          n0;
        int          gap;
        logic [7:0]  b1;
        int          n1;
        int          nv;
        int          nf;
        logic [11:0] d;
        logic        p;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tbl[12];
    int   checks   = 0;
    int   failures = 0;
    int   half     = 10;

    bit          m_pend = 1'b0;
    logic [7:0]  m_hi   = '0;
    logic [11:0] m_data = '0;
    logic        m_pad  = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            if (bus.rx_valid) begin
                e.is_v = 1'b1; e.d = bus.rx_data; e.p = bus.pad_err;
                obs_q.push_back(e);
            end
            if (bus.frame_err) begin
                e.is_v = 1'b0; e.d = '0; e.p = 1'b0;
                obs_q.push_back(e);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push_ferr();
        ev_t e;
        e.is_v = 1'b0; e.d = '0; e.p = 1'b0;
        exp_q.push_back(e);
    endtask

    // One SS-low window with n falling SCL edges, preceded by gap_before clk of SS high.
    task automatic model_window(input int gap_before, input logic [7:0] b, input int n);
        ev_t e;
        if (m_pend && gap_before >= GT) begin
            push_ferr();
            m_pend = 1'b0;
        end
        if (!m_pend) begin
            if (n == 8) begin m_pend = 1'b1; m_hi = b; end
            else push_ferr();
        end else begin
            m_pend = 1'b0;
            if (n == 8) begin
                m_data = {m_hi[3:0], b};
                m_pad  = |m_hi[7:4];
                e.is_v = 1'b1; e.d = m_data; e.p = m_pad;
                exp_q.push_back(e);
            end else push_ferr();
        end
    endtask

    task automatic send_window(input logic [7:0] b, input int n);
        bus.SS = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bus.SCL  = 1'b1;
            bus.MOSI = b[7 - (i % 8)];
            repeat (half) @(negedge clk);
            bus.SCL = 1'b0;
            repeat (half) @(negedge clk);
        end
        bus.SS = 1'b1;
    endtask

    task automatic run_entry(input logic [7:0] b0, input int n0, input int gap,
                             input logic [7:0] b1, input int n1);
        send_window(b0, n0);
        model_window(0, b0, n0);
        repeat (gap) @(negedge clk);
        send_window(b1, n1);
        model_window(gap, b1, n1);
        repeat (S + 4) @(negedge clk);
        chk("busy_after_entry", bus.busy, m_pend);
        if (m_pend) begin
            repeat (GT + 50) @(negedge clk);
            m_pend = 1'b0;
            push_ferr();
        end
    endtask

    task automatic compare_model(input string nm);
        int n;
        chk({nm, "_ev_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_ev_kind"}, obs_q[i].is_v, exp_q[i].is_v);
            if (obs_q[i].is_v && exp_q[i].is_v) begin
                chk({nm, "_ev_data"}, obs_q[i].d, exp_q[i].d);
                chk({nm, "_ev_pad"}, obs_q[i].p, exp_q[i].p);
            end
        end
        chk({nm, "_rx_data_hold"}, bus.rx_data, m_data);
        chk({nm, "_pad_err_hold"}, bus.pad_err, m_pad);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cnt, nv, nf;
        logic [7:0] rb0, rb1;
        int rn0, rn1, rgap;

        tbl[0]  = '{8'h09, 8, 200,  8'h25, 8, 1, 0, 12'h925, 1'b0};
        tbl[1]  = '{8'hF9, 8, 200,  8'h25, 8, 1, 0, 12'h925, 1'b1};
        tbl[2]  = '{8'h09, 8, 200,  8'h25, 8, 1, 0, 12'h925, 1'b0};
        tbl[3]  = '{8'h09, 7, 200,  8'h25, 8, 0, 2, 12'h925, 1'b0};
        tbl[4]  = '{8'h09, 8, 200,  8'h25, 8, 1, 0, 12'h925, 1'b0};
        tbl[5]  = '{8'h09, 8, 1200, 8'h25, 8, 0, 2, 12'h925, 1'b0};
        tbl[6]  = '{8'hA3, 8, 200,  8'h5C, 6, 0, 1, 12'h925, 1'b0};
        tbl[7]  = '{8'h0A, 8, 200,  8'hA5, 9, 0, 1, 12'h925, 1'b0};
        tbl[8]  = '{8'h3C, 8, S+2,  8'h7E, 8, 1, 0, 12'hC7E, 1'b1};
        tbl[9]  = '{8'h09, 8, S+2,  8'h25, 8, 1, 0, 12'h925, 1'b0};
        tbl[10] = '{8'h00, 8, S+2,  8'hA5, 8, 1, 0, 12'h0A5, 1'b0};
        tbl[11] = '{8'h00, 0, 200,  8'hFF, 8, 0, 2, 12'h0A5, 1'b0};

        rst = 1'b0; bus.SS = 1'b1; bus.SCL = 1'b0; bus.MOSI = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rx_data", bus.rx_data, 12'h0);
        chk("reset_rx_valid", bus.rx_valid, 1'b0);
        chk("reset_pad_err", bus.pad_err, 1'b0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal word at the real 250 kHz rate.
        half = 100;
        run_entry(8'h09, 8, 200, 8'h25, 8);
        compare_model("nominal");
        chk("nominal_rx_data", bus.rx_data, 12'h925);

        // Latency of busy rise and frame_err strobe on a 7-bit byte 0.
        half = 10;
        bus.SS = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (bus.busy) break;
        end
        chk("busy_rise_latency", cnt, S + 2);
        repeat (half) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            bus.SCL = 1'b1; bus.MOSI = i[0];
            repeat (half) @(negedge clk);
            bus.SCL = 1'b0;
            repeat (half) @(negedge clk);
        end
        chk("busy_before_ferr", bus.busy, 1'b1);
        bus.SS = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (bus.frame_err) break;
        end
        chk("ferr_latency", cnt, S + 2);
        chk("busy_falls_with_ferr", bus.busy, 1'b0);
        @(negedge clk);
        chk("ferr_one_cycle", bus.frame_err, 1'b0);
        model_window(0, 8'h55, 7);
        compare_model("short_latency");

        // Directed vector table.
        half = 25;
        for (int t = 0; t < 12; t++) begin
            run_entry(tbl[t].b0, tbl[t].n0, tbl[t].gap, tbl[t].b1, tbl[t].n1);
            nv = 0; nf = 0;
            foreach (obs_q[k]) if (obs_q[k].is_v) nv++; else nf++;
            chk($sformatf("tbl%0d_valid_count", t), nv, tbl[t].nv);
            chk($sformatf("tbl%0d_ferr_count", t), nf, tbl[t].nf);
            chk($sformatf("tbl%0d_rx_data", t), bus.rx_data, tbl[t].d);
            chk($sformatf("tbl%0d_pad_err", t), bus.pad_err, tbl[t].p);
            obs_q.delete();
            exp_q.delete();
            repeat (S + 2) @(negedge clk);
        end

        // Randomized transfers against the model.
        half = 6;
        for (int r = 0; r < 20; r++) begin
            rb0  = 8'($urandom);
            rb1  = 8'($urandom);
            rn0  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 8;
            rn1  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 8;
            rgap = ($urandom_range(0, 5) == 0) ? $urandom_range(1300, 1400)
                                               : $urandom_range(S + 2, 300);
            run_entry(rb0, rn0, rgap, rb1, rn1);
            compare_model($sformatf("rand%0d", r));
        end

        // Reset in the middle of byte 1.
        half = 10;
        send_window(8'h09, 8);
        repeat (20) @(negedge clk);
        bus.SS = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.SCL = 1'b1; bus.MOSI = i[0];
            repeat (half) @(negedge clk);
            bus.SCL = 1'b0;
            repeat (half) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("midrst_rx_data", bus.rx_data, 12'h0);
        chk("midrst_rx_valid", bus.rx_valid, 1'b0);
        chk("midrst_pad_err", bus.pad_err, 1'b0);
        chk("midrst_frame_err", bus.frame_err, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        bus.SS = 1'b1; bus.SCL = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        m_pend = 1'b0; m_data = '0; m_pad = 1'b0;
        obs_q.delete(); exp_q.delete();
        repeat (5) @(negedge clk);
        run_entry(8'h09, 8, 200, 8'h25, 8);
        compare_model("post_reset");
        chk("post_reset_rx_data", bus.rx_data, 12'h925);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
